// File: rtl/generic_2clk_fifo_rd_pkg.sv
// generic_2clk_fifo_rd_pkg: shared FSM type, latency limits and buffer sizing for the FIFO read drain.
package generic_2clk_fifo_rd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, STOP} drain_state_t;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;
   function automatic int depth_of(input int rd_latency);
      return rd_latency + 1;
   endfunction
endpackage

// File: rtl/generic_sync_skid_fifo.sv
// generic_sync_skid_fifo: single-clock shift buffer; the head word lives directly in a register.
module generic_sync_skid_fifo
   import generic_2clk_fifo_rd_pkg::*;
#(
   parameter int DAT_WIDTH = 20,
   parameter int DEPTH     = 2
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_push,
   input  logic [DAT_WIDTH-1:0]         i_data,
   input  logic                         i_pop,
   output logic                         o_valid,
   output logic [DAT_WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_occ,
   output logic                         o_ovf
);
   localparam int OW = $clog2(DEPTH + 1);
   logic [DEPTH-1:0][DAT_WIDTH-1:0] r_mem, w_mem_nxt;
   logic [OW-1:0] r_occ, w_wr_idx;
   logic w_full, w_pop, w_push_ok;
   assign w_full    = r_occ == OW'(DEPTH);
   assign w_pop     = i_pop & (r_occ != '0);
   assign w_push_ok = i_push & (~w_full | w_pop);
   assign w_wr_idx  = w_pop ? r_occ - OW'(1) : r_occ;
   // Popping shifts every slot down one; a push lands just above the surviving words.
   always_comb begin
      w_mem_nxt = w_pop ? r_mem >> DAT_WIDTH : r_mem;
      for (int i = 0; i < DEPTH; i++)
         if (w_push_ok && w_wr_idx == OW'(i)) w_mem_nxt[i] = i_data;
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_mem <= '0;
         r_occ <= '0;
      end else begin
         r_mem <= w_mem_nxt;
         r_occ <= r_occ + OW'(w_push_ok) - OW'(w_pop);
      end
   assign o_valid = r_occ != '0;
   assign o_data  = r_mem[0];
   assign o_occ   = r_occ;
   assign o_ovf   = i_push & w_full & ~w_pop;
endmodule

// File: rtl/generic_2clk_fifo_rd_drain.sv
// generic_2clk_fifo_rd_drain: pops the dual-clock FIFO read port and streams the words out as valid/ready.
module generic_2clk_fifo_rd_drain
   import generic_2clk_fifo_rd_pkg::*;
#(
   parameter int DAT_WIDTH  = 20,
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16
)(
   input  logic                  i_rd_clk,
   input  logic                  i_rd_reset,
   input  logic                  i_drain_en,
   input  logic                  i_rd_empty,
   input  logic                  i_rd_empty_err,
   input  logic [DAT_WIDTH-1:0]  i_rd_data,
   output logic                  o_rd_op,
   output logic                  o_out_valid,
   output logic [DAT_WIDTH-1:0]  o_out_data,
   input  logic                  i_out_ready,
   output logic                  o_busy,
   output logic                  o_err_sticky,
   input  logic                  i_err_clr,
   output logic [CNT_WIDTH-1:0]  o_rd_count
);
   localparam int DEPTH = depth_of(RD_LATENCY);
   localparam int OW    = $clog2(DEPTH + 1);
   localparam int SW    = OW + 2;
   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
      $error("RD_LATENCY must be 1 or 2");
   end
   function automatic logic [SW-1:0] popcnt(input logic [RD_LATENCY-1:0] v);
      popcnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) popcnt = popcnt + SW'(v[i]);
   endfunction
   drain_state_t r_state;
   logic [RD_LATENCY-1:0] r_vpipe, w_vpipe_nxt;
   logic [OW-1:0] w_occ;
   logic [SW-1:0] w_infl, w_infl_nxt, w_level;
   logic [CNT_WIDTH-1:0] r_count;
   logic r_err, w_valid, w_pop, w_rd_op, w_ovf;
   // Level seen by a new read: buffered plus in flight, less the word leaving this cycle.
   assign w_pop       = w_valid & i_out_ready;
   assign w_infl      = popcnt(r_vpipe);
   assign w_level     = SW'(w_occ) + w_infl - SW'(w_pop);
   assign w_rd_op     = r_state == RUN && w_level < SW'(DEPTH) && !i_rd_empty;
   assign w_vpipe_nxt = RD_LATENCY'({r_vpipe, w_rd_op});
   assign w_infl_nxt  = popcnt(w_vpipe_nxt);
   generic_sync_skid_fifo #(.DAT_WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_buf (
      .i_clk   (i_rd_clk),
      .i_rst   (i_rd_reset),
      .i_push  (r_vpipe[RD_LATENCY-1]),
      .i_data  (i_rd_data),
      .i_pop   (w_pop),
      .o_valid (w_valid),
      .o_data  (o_out_data),
      .o_occ   (w_occ),
      .o_ovf   (w_ovf)
   );
   always_ff @(posedge i_rd_clk or posedge i_rd_reset)
      if (i_rd_reset) begin
         r_state <= IDLE;
         r_vpipe <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_vpipe <= w_vpipe_nxt;
         r_count <= r_count + CNT_WIDTH'(w_rd_op);
         r_err   <= i_rd_empty_err | w_ovf | (r_err & ~i_err_clr);
         case (r_state)
            IDLE:    if (i_drain_en) r_state <= RUN;
            RUN:     if (!i_drain_en) r_state <= (w_infl_nxt == '0) ? IDLE : STOP;
            STOP:    if (i_drain_en) r_state <= RUN;
                     else if (w_infl_nxt == '0) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   assign o_rd_op      = w_rd_op;
   assign o_out_valid  = w_valid;
   assign o_busy       = (r_state != IDLE) | w_valid;
   assign o_err_sticky = r_err;
   assign o_rd_count   = r_count;
endmodule

// File: tb/tb_generic_2clk_fifo_rd_drain.sv
// tb_generic_2clk_fifo_rd_drain: directed bench; u_a uses RD_LATENCY=1, u_b uses RD_LATENCY=2 with a 4-bit counter.
module tb_generic_2clk_fifo_rd_drain;
   localparam int DW = 20;
   logic clk = 1'b0, rst = 1'b1;
   logic drain_a = 1'b0, drain_b = 1'b0, force_empty = 1'b0, empty_err = 1'b0;
   logic err_clr = 1'b0, out_ready = 1'b0, sel = 1'b0, pop_q = 1'b0;
   logic rd_empty;
   logic [DW-1:0] rd_data, d1 = '0, d2 = '0;
   logic [DW-1:0] mem [256];
   int head = 0, tail = 0, checks = 0, errors = 0;
   logic rd_op_a, valid_a, busy_a, err_a, rd_op_b, valid_b, busy_b, err_b;
   logic [DW-1:0] data_a, data_b;
   logic [15:0] count_a;
   logic [3:0] count_b;

   generic_2clk_fifo_rd_drain #(.DAT_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(16)) u_a (
      .i_rd_clk(clk), .i_rd_reset(rst), .i_drain_en(drain_a), .i_rd_empty(rd_empty),
      .i_rd_empty_err(empty_err), .i_rd_data(rd_data), .o_rd_op(rd_op_a), .o_out_valid(valid_a),
      .o_out_data(data_a), .i_out_ready(out_ready), .o_busy(busy_a), .o_err_sticky(err_a),
      .i_err_clr(err_clr), .o_rd_count(count_a));
   generic_2clk_fifo_rd_drain #(.DAT_WIDTH(DW), .RD_LATENCY(2), .CNT_WIDTH(4)) u_b (
      .i_rd_clk(clk), .i_rd_reset(rst), .i_drain_en(drain_b), .i_rd_empty(rd_empty),
      .i_rd_empty_err(empty_err), .i_rd_data(rd_data), .o_rd_op(rd_op_b), .o_out_valid(valid_b),
      .o_out_data(data_b), .i_out_ready(out_ready), .o_busy(busy_b), .o_err_sticky(err_b),
      .i_err_clr(err_clr), .o_rd_count(count_b));

   always #5 clk = ~clk;
   // FIFO/RAM model: d1 is data one cycle after the pop, d2 two cycles after.
   assign rd_empty = force_empty || head == tail;
   assign rd_data  = sel ? d2 : d1;
   always @(negedge clk) pop_q <= sel ? rd_op_b : rd_op_a;
   always @(posedge clk) begin
      if (pop_q && head != tail) begin
         d1   <= mem[head % 256];
         head <= head + 1;
      end
      d2 <= d1;
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) mem[(tail + i) % 256] = base + DW'(i);
      tail = tail + n;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc;
      cyc;
      @(negedge clk);
      checks++;
      if ({rd_op_a, valid_a, busy_a, err_a} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags_a: got %b want 0000", {rd_op_a, valid_a, busy_a, err_a});
      end
      checks++;
      if ({rd_op_b, valid_b, busy_b, err_b} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags_b: got %b want 0000", {rd_op_b, valid_b, busy_b, err_b});
      end
      checks++;
      if (data_a !== '0 || data_b !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h want 0/0", data_a, data_b);
      end
      checks++;
      if (count_a !== '0 || count_b !== '0) begin
         errors++;
         $display("FAIL reset_count: got %0d/%0d want 0/0", count_a, count_b);
      end
      cyc;
      rst = 1'b0;
      cyc;
   endtask

   task automatic test_basic;
      logic e;
      logic [15:0] ec;
      load(8, 20'h00001);
      sel = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         drain_a = c <= 10;
         @(negedge clk);
         e = c >= 1 && c <= 8;
         checks++;
         if (rd_op_a !== e) begin errors++; $display("FAIL basic_rd_op c%0d: got %b want %b", c, rd_op_a, e); end
         e = c >= 3 && c <= 10;
         checks++;
         if (valid_a !== e) begin errors++; $display("FAIL basic_valid c%0d: got %b want %b", c, valid_a, e); end
         if (e) begin
            checks++;
            if (data_a !== DW'(c - 2)) begin errors++; $display("FAIL basic_data c%0d: got %h want %h", c, data_a, DW'(c - 2)); end
         end
         e = c >= 1 && c <= 11;
         checks++;
         if (busy_a !== e) begin errors++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy_a, e); end
         ec = 16'(c < 2 ? 0 : (c > 9 ? 8 : c - 1));
         checks++;
         if (count_a !== ec) begin errors++; $display("FAIL basic_count c%0d: got %0d want %0d", c, count_a, ec); end
         cyc;
      end
   endtask

   task automatic test_backpressure;
      int issued = 0, acc = 0;
      load(10, 20'h00100);
      sel = 1'b1;
      drain_b = 1'b1;
      for (int c = 0; c < 80 && acc < 10; c++) begin
         out_ready = ((c / 3) % 2) == 1;
         @(negedge clk);
         checks++;
         if (issued - acc > 3) begin errors++; $display("FAIL bp_level c%0d: got %0d want <=3", c, issued - acc); end
         if (rd_op_b) issued++;
         if (valid_b && out_ready) begin
            checks++;
            if (data_b !== 20'h00100 + DW'(acc)) begin
               errors++;
               $display("FAIL bp_data #%0d: got %h want %h", acc, data_b, 20'h00100 + DW'(acc));
            end
            acc++;
         end
         cyc;
      end
      drain_b = 1'b0;
      out_ready = 1'b1;
      cyc;
      cyc;
      @(negedge clk);
      checks++;
      if (acc != 10 || issued != 10) begin errors++; $display("FAIL bp_totals: got %0d/%0d want 10/10", acc, issued); end
      checks++;
      if ({valid_b, busy_b, err_b} !== 3'b000) begin errors++; $display("FAIL bp_idle: got %b want 000", {valid_b, busy_b, err_b}); end
      checks++;
      if (count_b !== 4'd10) begin errors++; $display("FAIL bp_count: got %0d want 10", count_b); end
      cyc;
   endtask

   task automatic test_stop;
      logic e;
      load(1, 20'h2AAAA);
      sel = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drain_b = c < 2;
         @(negedge clk);
         e = c == 1;
         checks++;
         if (rd_op_b !== e) begin errors++; $display("FAIL stop_rd_op c%0d: got %b want %b", c, rd_op_b, e); end
         e = c == 4;
         checks++;
         if (valid_b !== e) begin errors++; $display("FAIL stop_valid c%0d: got %b want %b", c, valid_b, e); end
         if (e) begin
            checks++;
            if (data_b !== 20'h2AAAA) begin errors++; $display("FAIL stop_data: got %h want 2aaaa", data_b); end
         end
         // Cycle 3 has nothing buffered, so busy there can only come from the STOP state.
         e = c >= 1 && c <= 4;
         checks++;
         if (busy_b !== e) begin errors++; $display("FAIL stop_busy c%0d: got %b want %b", c, busy_b, e); end
         cyc;
      end
   endtask

   task automatic test_empty_err;
      logic e;
      load(3, 20'h00300);
      sel = 1'b0;
      force_empty = 1'b1;
      for (int c = 0; c < 8; c++) begin
         drain_a   = c < 6;
         empty_err = c == 0 || c == 3 || c == 4;
         err_clr   = c == 2 || c == 4 || c == 5;
         @(negedge clk);
         checks++;
         if (rd_op_a !== 1'b0) begin errors++; $display("FAIL empty_gate c%0d: got %b want 0", c, rd_op_a); end
         e = c == 1 || c == 2 || c == 4 || c == 5;
         checks++;
         if (err_a !== e) begin errors++; $display("FAIL err_sticky c%0d: got %b want %b", c, err_a, e); end
         cyc;
      end
      empty_err = 1'b0;
      err_clr = 1'b0;
      cyc;
      force_empty = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic e;
      sel = 1'b1;
      out_ready = 1'b0;
      drain_b = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         e = c >= 1 && c <= 3;
         checks++;
         if (rd_op_b !== e) begin errors++; $display("FAIL rst_fill_rd_op c%0d: got %b want %b", c, rd_op_b, e); end
         e = c == 4;
         checks++;
         if (valid_b !== e) begin errors++; $display("FAIL rst_fill_valid c%0d: got %b want %b", c, valid_b, e); end
         cyc;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({rd_op_b, valid_b, busy_b, err_b} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_mid_flags: got %b want 0000", {rd_op_b, valid_b, busy_b, err_b});
      end
      checks++;
      if (data_b !== '0 || count_b !== '0) begin errors++; $display("FAIL rst_mid_data_count: got %h/%0d want 0/0", data_b, count_b); end
      cyc;
      rst = 1'b0;
      drain_b = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({valid_b, busy_b} !== 2'b00) begin errors++; $display("FAIL rst_late_data c%0d: got %b want 00", c, {valid_b, busy_b}); end
         cyc;
      end
   endtask

   task automatic test_count_wrap;
      int issued = 0, acc = 0;
      load(17, 20'h00400);
      sel = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (count_b !== 4'd0) begin errors++; $display("FAIL wrap_start: got %0d want 0", count_b); end
      cyc;
      drain_b = 1'b1;
      for (int c = 0; c < 80 && acc < 17; c++) begin
         @(negedge clk);
         if (rd_op_b) issued++;
         if (valid_b) begin
            checks++;
            if (data_b !== 20'h00400 + DW'(acc)) begin
               errors++;
               $display("FAIL wrap_data #%0d: got %h want %h", acc, data_b, 20'h00400 + DW'(acc));
            end
            acc++;
         end
         cyc;
      end
      drain_b = 1'b0;
      cyc;
      cyc;
      @(negedge clk);
      checks++;
      if (acc != 17 || issued != 17) begin errors++; $display("FAIL wrap_totals: got %0d/%0d want 17/17", acc, issued); end
      checks++;
      if (count_b !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", count_b); end
      cyc;
   endtask

   initial begin
      #1;
      test_reset;
      test_basic;
      test_backpressure;
      test_stop;
      test_empty_err;
      test_reset_mid;
      test_count_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule

// File: doc/generic_2clk_fifo_rd_drain.md
# generic_2clk_fifo_rd_drain

Read-side consumer for the generic dual-clock FIFO envelope: sits in the read clock domain and pops entries from the FIFO port. It accounts for the fixed read latency of the compiled RAM and presents the popped words as a valid/ready stream. A small prefetch buffer sustains one word per cycle under continuous `out_ready`. It also tracks enable/stop sequencing, a wrapping word counter and a sticky underflow error.

## Interface
- `DAT_WIDTH`, 20, width of FIFO data and stream data.
- `RD_LATENCY`, 1, cycles from `rd_op` to valid `rd_data`; legal values are 1 and 2.
- `CNT_WIDTH`, 16, width of the popped-word counter.
- `rd_clk`  in  1  read-domain clock; all logic is on its rising edge.
- `rd_reset`  in  1  asynchronous, active-high reset.
- `drain_en`  in  1  level; while high, the block pops whenever possible.
- `rd_empty`  in  1  FIFO empty flag, read domain.
- `rd_empty_err`  in  1  FIFO read-while-empty pulse.
- `rd_data`  in  DAT_WIDTH  RAM read data.
- `rd_op`  out  1  FIFO pop / RAM read enable.
- `out_valid`  out  1  stream word available.
- `out_data`  out  DAT_WIDTH  stream word.
- `out_ready`  in  1  downstream accepts when high together with `out_valid`.
- `busy`  out  1  high when the state is not IDLE, or the buffer is non-empty.
- `err_sticky`  out  1  latched underflow error.
- `err_clr`  in  1  clears `err_sticky`.
- `rd_count`  out  CNT_WIDTH  number of `rd_op` pulses issued, wraps modulo 2^CNT_WIDTH.

## Operation
- **Buffer:** depth is DEPTH = RD_LATENCY+1.
  - `occ` is the number of buffered words.
  - `infl` is the number of reads in flight, tracked by a valid shift register of length RD_LATENCY.
- **`rd_op` condition:** `rd_op = issue_ok & ~rd_empty`.
  - `issue_ok` is the state being RUN and `occ + infl - (out_valid & out_ready) < DEPTH`.
  - This gives a combinational path from `out_ready` to `rd_op`; that path is intended.
- **FSM states:**
  - IDLE: entered from reset. Moves to RUN when `drain_en`=1.
  - RUN: issues reads. When `drain_en`=0, moves to IDLE if `infl`=0 after this cycle, otherwise to STOP. A read can be issued in the same cycle that `drain_en` falls.
  - STOP: no new reads. Moves to IDLE when the last in-flight word has been captured. If `drain_en` rises again while in STOP, the FSM returns to RUN directly.
- **Output buffer:** presents its head word independent of FSM state, so buffered words still drain while in IDLE.
- **Counter:** `rd_count` increments by 1 on each `rd_op`.
- **Error:**
  - `err_sticky` sets on `rd_empty_err`=1.
  - It also sets if the valid pipe ever tries to capture into a full buffer (internal overflow; must never happen).
  - `err_clr` clears it. Set wins over a simultaneous clear.
- **Reset:** `rd_reset` asserted at any time clears the FSM, `occ`, `infl`, `rd_count` and `err_sticky` immediately. Words already popped from the FIFO but not yet delivered are discarded; they are not recovered.

## Timing
- **Reset values:** `rd_op`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err_sticky`=0, `rd_count`=0.
- **Read latency:** with `rd_op`=1 in cycle t, `rd_data` is sampled at the end of cycle t+RD_LATENCY.
- **First output:** `out_valid`=1 from cycle t+RD_LATENCY+1. With the FIFO non-empty and `drain_en` rising in cycle 0, the FSM is in RUN in cycle 1 and the first `rd_op` is in cycle 1.
- **Throughput:** one word per cycle when `rd_empty`=0 and `out_ready`=1 continuously.
- **Backpressure:** with `out_ready`=0, issuing stops once `occ + infl` = DEPTH. No word is dropped or duplicated.
- **Stream stability:** `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- **FIFO empty:** `rd_op` stays low whenever `rd_empty`=1, regardless of other inputs.
- **Simultaneous push and pop:** a capture into a full buffer in the same cycle as a pop is legal; `occ` is unchanged.

## Structure
- **Package `generic_2clk_fifo_rd_pkg`:**
  - FSM state typedef (IDLE, RUN, STOP).
  - Constants `RD_LAT_MIN`=1 and `RD_LAT_MAX`=2.
  - A DEPTH function of RD_LATENCY.
- **Sub-module `generic_sync_skid_fifo`:** single-clock, registered-output buffer with parameters DAT_WIDTH and DEPTH. Push/pop/occ interface; it holds the output buffer.
- **Top level:** the FSM, the in-flight valid pipe, the counter and the error logic.

## Test plan
- **Basic stream:** RD_LATENCY=1, FIFO preloaded with 0x00001..0x00008, `drain_en`=1, `out_ready`=1 → `rd_op` high for cycles 1..8; `out_valid` in cycles 3..10 carrying 0x00001..0x00008 in order; `rd_count`=8; `busy` falls after the last word is accepted.
- **Backpressure:** RD_LATENCY=2, 10 words, `out_ready` toggled 0/1 every 3 cycles → all 10 words delivered in order; `occ + infl` never exceeds 3; `err_sticky`=0.
- **Stop with in-flight reads:** `drain_en` dropped in the cycle after a `rd_op` with RD_LATENCY=2 → FSM goes RUN→STOP→IDLE; no further `rd_op`; the in-flight word is still delivered.
- **Empty gating and error:** `rd_empty`=1 with `drain_en`=1 → `rd_op`=0. A pulse on `rd_empty_err` → `err_sticky`=1 until `err_clr`. `rd_empty_err` and `err_clr` asserted in the same cycle → `err_sticky` stays 1.
- **Reset mid-operation:** `rd_reset` pulsed with 2 words buffered and 1 in flight → all outputs take their reset values immediately; a late `rd_data` is not captured.
- **Counter wrap:** CNT_WIDTH=4, 17 pops → `rd_count`=1.
